// File: rtl/pio_buttons_poller.sv
// -----------------------------------------------------------------------------
// pio_buttons_poller
//
// Drains the edge-capture register of a button PIO without CPU involvement.
// A free-running timer raises a one-cycle tick every POLL_PERIOD cycles. On a
// tick (when enabled and the event FIFO has room) the block reads the PIO
// edge-capture register (address 3). If any bit is set, it writes exactly
// those bits back to clear them and queues the bit vector as one event in a
// first-word-fall-through FIFO drained through a valid/ready port.
//
// Parameters
//   POLL_PERIOD  cycles between poll ticks (>= 4)
//   WIDTH        number of buttons (PIO in_port width)
//   FIFO_DEPTH   event FIFO entries (power of two, >= 2)
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   enable          poll enable; ticks are ignored while low
//   avm_address     PIO register address          (to PIO s1)
//   avm_chipselect  PIO chipselect                (to PIO s1)
//   avm_write_n     PIO write strobe, active-low  (to PIO s1)
//   avm_writedata   PIO write data                (to PIO s1)
//   avm_readdata    PIO read data, valid one cycle after the address
//   evt_valid       event FIFO non-empty
//   evt_data        head event, one bit per button that saw a rising edge
//   evt_ready       consumer pops the head event when high with evt_valid
//   fifo_level      current number of queued events
//   skip_cnt        saturating count of ticks skipped because the FIFO was full
// -----------------------------------------------------------------------------
module pio_buttons_poller #(
  parameter int POLL_PERIOD = 50000,
  parameter int WIDTH       = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  output logic [1:0]                    avm_address,
  output logic                          avm_chipselect,
  output logic                          avm_write_n,
  output logic [31:0]                   avm_writedata,
  input  logic [31:0]                   avm_readdata,
  output logic                          evt_valid,
  output logic [WIDTH-1:0]              evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    skip_cnt
);

  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0]    EDGE_CAP_ADDR = 2'd3;
  localparam logic [TW-1:0] TICK_AT       = TW'(POLL_PERIOD - 1);
  localparam logic [LW-1:0] FULL_LEVEL    = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_CLEAR
  } state_t;

  // ---------------------------------------------------------------------------
  // Tick timer: free-running, independent of the FSM and of enable.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] r_timer;
  logic          w_tick;

  assign w_tick = (r_timer == TICK_AT);

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking (=) here would create ordering
  // dependent races between always_ff blocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO status (needed by the FSM to decide between polling and skipping)
  // ---------------------------------------------------------------------------
  logic [LW-1:0] r_level;
  logic          w_full;
  logic          w_empty;

  assign w_full  = (r_level == FULL_LEVEL);
  assign w_empty = (r_level == '0);

  // ---------------------------------------------------------------------------
  // Poll FSM. Bus outputs are decoded from the state register, so an
  // asynchronous reset forces the bus idle immediately.
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_rd_bits;
  logic             w_unused_rdata;

  assign w_rd_bits      = avm_readdata[WIDTH-1:0];
  // Upper readdata bits carry nothing for a WIDTH-bit edge register.
  assign w_unused_rdata = ^avm_readdata[31:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next         = r_state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'd0;
    avm_writedata  = 32'd0;
    case (r_state)
      S_IDLE: begin
        // A full FIFO leaves the edges pending in the PIO rather than
        // reading them and having nowhere to put them.
        if (w_tick && enable && !w_full) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        avm_chipselect = 1'b1;
        avm_address    = EDGE_CAP_ADDR;
        w_next         = S_CAPTURE;
      end
      S_CAPTURE: begin
        // PIO readdata is registered, so the edge bits arrive now.
        avm_address = EDGE_CAP_ADDR;
        w_next      = (w_rd_bits != '0) ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: begin
        // Only the captured bits are written as 1, so edges that arrived
        // on other bits during this transaction stay pending.
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = EDGE_CAP_ADDR;
        avm_writedata  = {{(32-WIDTH){1'b0}}, r_cap};
        w_next         = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_cap <= w_rd_bits;
    end
  end

  // ---------------------------------------------------------------------------
  // Skip counter: ticks dropped because the FIFO was full, saturating.
  // ---------------------------------------------------------------------------
  logic [7:0] r_skip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skip <= 8'd0;
    end else if ((r_state == S_IDLE) && w_tick && enable && w_full &&
                 (r_skip != 8'hFF)) begin
      r_skip <= r_skip + 8'd1;
    end
  end

  assign skip_cnt = r_skip;

  // ---------------------------------------------------------------------------
  // Event FIFO, first-word-fall-through. A push happens on the edge that ends
  // CLEAR; fullness was already checked at the tick, so it never overflows.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = (r_state == S_CLEAR);
  assign w_pop  = evt_ready && !w_empty;

  // NOTE: the storage array has no reset; the level counter and pointers are
  // reset instead, and evt_data is masked while empty, so stale contents are
  // never observable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_cap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign evt_valid  = !w_empty;
  assign evt_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_level = r_level;

endmodule

// File: tb/tb_pio_buttons_poller.sv
// -----------------------------------------------------------------------------
// tb_pio_buttons_poller
//
// Bench for pio_buttons_poller with a short poll period. A small behavioural
// PIO (rising-edge capture on two buttons, registered readdata, bit-clearing
// writes to address 3) sits on the Avalon-MM side. Expected events are queued
// when button edges are injected and compared in order as the consumer pops
// them. Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_pio_buttons_poller;

  localparam int P  = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    avm_address;
  logic          avm_chipselect;
  logic          avm_write_n;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic          evt_valid;
  logic [1:0]    evt_data;
  logic          evt_ready;
  logic [LW-1:0] fifo_level;
  logic [7:0]    skip_cnt;

  always #5 clk = ~clk;

  pio_buttons_poller #(
    .POLL_PERIOD (P),
    .WIDTH       (2),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .evt_valid      (evt_valid),
    .evt_data       (evt_data),
    .evt_ready      (evt_ready),
    .fifo_level     (fifo_level),
    .skip_cnt       (skip_cnt)
  );

  // ---------------------------------------------------------------------------
  // Behavioural button PIO
  // ---------------------------------------------------------------------------
  logic       pio_rst_n;
  logic [1:0] buttons;
  logic [1:0] pio_btn_d;
  logic [1:0] pio_edge;
  logic [31:0] pio_rdata;

  assign avm_readdata = pio_rdata;

  always @(posedge clk or negedge pio_rst_n) begin
    if (!pio_rst_n) begin
      pio_btn_d <= 2'b00;
      pio_edge  <= 2'b00;
      pio_rdata <= 32'd0;
    end else begin
      pio_btn_d <= buttons;
      pio_rdata <= (avm_address == 2'd3) ? {30'd0, pio_edge} : 32'd0;
      pio_edge  <= ((avm_chipselect && !avm_write_n && avm_address == 2'd3) ?
                    (pio_edge & ~avm_writedata[1:0]) : pio_edge)
                   | (buttons & ~pio_btn_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and bus activity monitor
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         bus_cnt  = 0;
  int         wr_cnt   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  always @(negedge clk) begin
    if (avm_chipselect) bus_cnt++;
    if (avm_chipselect && !avm_write_n) wr_cnt++;
    if (reset_n && evt_valid && evt_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got evt_data=%b, expected no event", evt_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (evt_data !== mon_exp)
          $display("FAIL pop_order: got evt_data=%b, expected %b", evt_data, mon_exp);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic pulse(input logic [1:0] b);
    @(posedge clk); #1 buttons = b;
    @(posedge clk); #1 buttons = 2'b00;
  endtask

  // Waits (bounded) for a READ cycle; n = falling edges consumed.
  task automatic wait_read(output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < 2*P) begin
      @(negedge clk);
      n++;
      if (avm_chipselect && avm_write_n) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL wait_read: got no READ within %0d cycles, expected one", 2*P);
    end
  endtask

  // Poll with nothing pending: READ, CAPTURE, back to IDLE.
  task automatic sync_to_poll();
    int n; bit f;
    wait_read(n, f);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Next poll must clear exactly 'bits'; returns at the CLEAR falling edge.
  task automatic poll_expect(input logic [1:0] bits);
    int n; bit f;
    wait_read(n, f);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (!(avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address === 2'd3))
      $display("FAIL clear_strobe: got cs=%b wn=%b addr=%0d, expected cs=1 wn=0 addr=3",
               avm_chipselect, avm_write_n, avm_address);
    else n_pass++;
    n_checks++;
    if (avm_writedata !== {30'd0, bits})
      $display("FAIL clear_data: got writedata=%h, expected %h", avm_writedata, {30'd0, bits});
    else n_pass++;
  endtask

  task automatic drain();
    int guard = 0;
    @(posedge clk); #1 evt_ready = 1'b1;
    while (fifo_level != 0 && guard < 4*D) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1 evt_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 3'd0 || evt_valid !== 1'b0)
      $display("FAIL drain_level: got level=%0d valid=%b, expected 0/0", fifo_level, evt_valid);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain_scoreboard: got %0d events outstanding, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (!(avm_chipselect === 1'b0 && avm_write_n === 1'b1 &&
          avm_address === 2'd0 && avm_writedata === 32'd0))
      $display("FAIL %s_bus: got cs=%b wn=%b addr=%0d wd=%h, expected 0/1/0/0", tag,
               avm_chipselect, avm_write_n, avm_address, avm_writedata);
    else n_pass++;
    n_checks++;
    if (!(evt_valid === 1'b0 && evt_data === 2'b00))
      $display("FAIL %s_evt: got valid=%b data=%b, expected 0/00", tag, evt_valid, evt_data);
    else n_pass++;
    n_checks++;
    if (!(fifo_level === 3'd0 && skip_cnt === 8'd0))
      $display("FAIL %s_counts: got level=%0d skip=%0d, expected 0/0", tag, fifo_level, skip_cnt);
    else n_pass++;
  endtask

  // Releases reset and checks the tick lands in cycle P-1, READ in cycle P.
  task automatic release_and_time_first_read();
    int n = 0;
    bit found = 1'b0;
    @(negedge clk); #1 reset_n = 1'b1;
    while (!found && n < 3*P) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (avm_chipselect) found = 1'b1;
    end
    n_checks++;
    if (!found || n != P || avm_write_n !== 1'b1 || avm_address !== 2'd3)
      $display("FAIL first_read: got read after %0d edges (found=%b wn=%b addr=%0d), expected %0d/1/1/3",
               n, found, avm_write_n, avm_address, P);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    pio_rst_n = 1'b1;
    release_and_time_first_read();
  endtask

  task automatic test_idle_poll();
    int n; bit f;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (avm_chipselect !== 1'b0 || avm_address !== 2'd3)
        $display("FAIL idle_capture: got cs=%b addr=%0d, expected 0/3", avm_chipselect, avm_address);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (avm_chipselect !== 1'b0 || avm_address !== 2'd0)
        $display("FAIL idle_back: got cs=%b addr=%0d, expected 0/0", avm_chipselect, avm_address);
      else n_pass++;
      wait_read(n, f);
      n_checks++;
      if (n != P-2 || avm_address !== 2'd3)
        $display("FAIL idle_period: got next read after %0d, addr=%0d, expected %0d/3", n, avm_address, P-2);
      else n_pass++;
    end
    n_checks++;
    if (wr_cnt != 0 || evt_valid !== 1'b0)
      $display("FAIL idle_nowrite: got writes=%0d valid=%b, expected 0/0", wr_cnt, evt_valid);
    else n_pass++;
  endtask

  task automatic test_single_edge();
    pulse(2'b10);
    exp_q.push_back(2'b10);
    poll_expect(2'b10);
    n_checks++;
    if (evt_valid !== 1'b0)
      $display("FAIL single_early: got valid=%b in CLEAR, expected 0", evt_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_data !== 2'b10 || fifo_level !== 3'd1)
      $display("FAIL single_event: got valid=%b data=%b level=%0d, expected 1/10/1",
               evt_valid, evt_data, fifo_level);
    else n_pass++;
    n_checks++;
    if (pio_edge !== 2'b00)
      $display("FAIL single_pio_clear: got edge_capture=%b, expected 00", pio_edge);
    else n_pass++;
    @(posedge clk); #1 evt_ready = 1'b1;
    @(posedge clk); #1 evt_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL single_pop: got valid=%b level=%0d, expected 0/0", evt_valid, fifo_level);
    else n_pass++;
  endtask

  task automatic test_capture_race();
    int n; bit f;
    sync_to_poll();
    pulse(2'b10);
    exp_q.push_back(2'b10);
    wait_read(n, f);
    @(posedge clk); #1 buttons = 2'b01;   // rises during CAPTURE
    exp_q.push_back(2'b01);
    @(negedge clk);
    @(posedge clk); #1 buttons = 2'b00;
    @(negedge clk);
    n_checks++;
    if (avm_write_n !== 1'b0 || avm_writedata !== 32'h2)
      $display("FAIL race_clear: got wn=%b wd=%h, expected 0/00000002", avm_write_n, avm_writedata);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (pio_edge !== 2'b01 || evt_data !== 2'b10)
      $display("FAIL race_survive: got pio=%b evt=%b, expected 01/10", pio_edge, evt_data);
    else n_pass++;
    poll_expect(2'b01);
    drain();
  endtask

  task automatic test_fifo_full();
    int b0;
    logic [1:0] b;
    sync_to_poll();
    for (int i = 0; i < D; i++) begin
      b = (i % 2 == 0) ? 2'b10 : 2'b01;
      pulse(b);
      exp_q.push_back(b);
      poll_expect(b);
    end
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 3'd4 || evt_data !== 2'b10)
      $display("FAIL full_level: got level=%0d head=%b, expected 4/10", fifo_level, evt_data);
    else n_pass++;
    pulse(2'b01);
    exp_q.push_back(2'b01);
    for (int w = 1; w <= 3; w++) begin
      if (w == 3) #1 enable = 1'b0;
      b0 = bus_cnt;
      repeat (P) @(negedge clk);
      n_checks++;
      if (bus_cnt != b0)
        $display("FAIL full_nobus: got %0d bus cycles in window %0d, expected 0", bus_cnt - b0, w);
      else n_pass++;
      n_checks++;
      if (skip_cnt !== ((w < 3) ? 8'(w) : 8'd2))
        $display("FAIL full_skip: got skip=%0d in window %0d, expected %0d",
                 skip_cnt, w, (w < 3) ? w : 2);
      else n_pass++;
    end
    #1 enable = 1'b1;
    n_checks++;
    if (pio_edge !== 2'b01)
      $display("FAIL full_pending: got pio=%b, expected 01", pio_edge);
    else n_pass++;
    @(posedge clk); #1 evt_ready = 1'b1;
    @(posedge clk); #1 evt_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 3'd3)
      $display("FAIL full_pop: got level=%0d, expected 3", fifo_level);
    else n_pass++;
    poll_expect(2'b01);
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 3'd4)
      $display("FAIL full_resume: got level=%0d, expected 4", fifo_level);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    int n; bit f;
    sync_to_poll();
    pulse(2'b10); exp_q.push_back(2'b10); poll_expect(2'b10);
    pulse(2'b01); exp_q.push_back(2'b01); poll_expect(2'b01);
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 3'd2)
      $display("FAIL b2b_pre: got level=%0d, expected 2", fifo_level);
    else n_pass++;
    pulse(2'b11);
    exp_q.push_back(2'b11);
    wait_read(n, f);
    @(negedge clk);
    @(posedge clk); #1 evt_ready = 1'b1;   // high across the push edge only
    @(negedge clk);
    @(posedge clk); #1 evt_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_level !== 3'd2 || evt_data !== 2'b01)
      $display("FAIL b2b_level: got level=%0d head=%b, expected 2/01", fifo_level, evt_data);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid_clear();
    int n; bit f;
    sync_to_poll();
    pulse(2'b10);
    exp_q.push_back(2'b10);   // the aborted write leaves it pending
    wait_read(n, f);
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (avm_write_n !== 1'b1 || avm_chipselect !== 1'b0)
      $display("FAIL rst_async: got wn=%b cs=%b, expected 1/0", avm_write_n, avm_chipselect);
    else n_pass++;
    check_reset_outputs("rst_mid");
    n_checks++;
    if (pio_edge !== 2'b10)
      $display("FAIL rst_pending: got pio=%b, expected 10", pio_edge);
    else n_pass++;
    repeat (2) @(negedge clk);
    release_and_time_first_read();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (avm_write_n !== 1'b0 || avm_writedata !== 32'h2)
      $display("FAIL rst_redeliver: got wn=%b wd=%h, expected 0/00000002", avm_write_n, avm_writedata);
    else n_pass++;
    drain();
  endtask

  initial begin
    reset_n   = 1'b0;
    pio_rst_n = 1'b0;
    enable    = 1'b1;
    evt_ready = 1'b0;
    buttons   = 2'b00;
    test_reset();
    test_idle_poll();
    test_single_edge();
    test_capture_race();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
